starfield_gen: RTL and testbench

- Pixel-generation stage fed directly by the display timing generator.
- Consumes pixel_x/pixel_y, video_on, hsync and vsync, and produces a scrolling white starfield background in 8-bit RGB.
- The sync and data-enable outputs are delayed to stay aligned with the RGB.
- Output feeds the sprite/overlay mixer and the HDMI encoder.

---
 rtl/starfield_gen.sv | 184 ++++++++++++++++++
 tb/tb_starfield_gen.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/starfield_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : starfield_gen
// Purpose  : Scrolling white starfield background generator. Sits directly
//            behind the display timing generator and emits 8-bit grey RGB
//            with sync/data-enable delayed to stay aligned with the pixels.
// Ports    : pixel_clk, reset_n (async, active low), pix_ce (pixel strobe)
//            pixel_x/pixel_y, hsync_in, vsync_in, video_on_in  - timing in
//            scroll_en, speed                                  - scroll ctrl
//            rgb_r/g/b, hsync_out, vsync_out, de_out            - 3-strobe
//                                                               latency
//            frame_tick - single pixel_clk pulse on vsync rising edge
// Options  : define STARFIELD_TWINKLE_EN to add a frame counter that flips
//            the brightness of roughly half the stars every 8 frames.
// Revision : 1.0 - initial release
// ============================================================================
module starfield_gen #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter logic [8:0]  DENSITY = 9'd12,
  parameter logic [9:0]  V_WRAP  = 10'd480
) (
  input  logic       pixel_clk,
  input  logic       reset_n,
  input  logic       pix_ce,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       video_on_in,
  input  logic       scroll_en,
  input  logic [2:0] speed,
  output logic [7:0] rgb_r,
  output logic [7:0] rgb_g,
  output logic [7:0] rgb_b,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       de_out,
  output logic       frame_tick
);

  localparam logic [15:0] c_LFSR_TAPS = 16'hB400;
  localparam logic [5:0]  c_SEED_LOW  = 6'b101011;
  localparam logic [10:0] c_WRAP      = {1'b0, V_WRAP};

  // frame edge / scroll state
  logic        r_vsync_prev;
  logic [9:0]  r_scroll_off;

  // stage 1
  logic [15:0] r_lfsr;
  logic        r_vid_d1;
  logic        r_hs_d1;
  logic        r_vs_d1;

  // stage 2
  logic        r_star;
  logic [7:0]  r_level;
  logic        r_de_d2;
  logic        r_hs_d2;
  logic        r_vs_d2;

  logic        w_vs_rise;
  logic [10:0] w_scroll_sum;
  logic [9:0]  w_scroll_next;
  logic [10:0] w_ys_sum;
  logic [9:0]  w_ys;
  logic [15:0] w_lfsr_step;
  logic [15:0] w_line_seed;
  logic [1:0]  w_level_idx;
  logic [7:0]  w_level;
  logic        w_star;
  logic        w_unused_x;

  // Column position is not needed: the per-line LFSR walk supplies the
  // horizontal variation.
  assign w_unused_x = ^pixel_x;

`ifdef STARFIELD_TWINKLE_EN
  logic [3:0] r_frame_cnt;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt <= 4'd0;
    end else if (w_vs_rise) begin
      r_frame_cnt <= r_frame_cnt + 4'd1;
    end
  end
`endif

  always_comb begin
    w_vs_rise = pix_ce & vsync_in & ~r_vsync_prev;

    // Sums are at most 2*V_WRAP-1 for in-range operands, so one
    // conditional subtract is enough.
    w_scroll_sum  = {1'b0, r_scroll_off} + {8'd0, speed};
    w_scroll_next = (w_scroll_sum >= c_WRAP) ? 10'(w_scroll_sum - c_WRAP)
                                             : w_scroll_sum[9:0];

    w_ys_sum = {1'b0, pixel_y} + {1'b0, r_scroll_off};
    w_ys     = (w_ys_sum >= c_WRAP) ? 10'(w_ys_sum - c_WRAP) : w_ys_sum[9:0];

    // Galois right-shift step; bit0 forced high on the seed keeps the
    // register out of the all-zero lock-up state.
    w_lfsr_step = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_LFSR_TAPS : 16'h0000);
    w_line_seed = ({w_ys, c_SEED_LOW} ^ SEED) | 16'h0001;

`ifdef STARFIELD_TWINKLE_EN
    w_level_idx = r_lfsr[7:6] ^ {r_frame_cnt[3] & r_lfsr[5], 1'b0};
`else
    w_level_idx = r_lfsr[7:6];
`endif

    case (w_level_idx)
      2'd0:    w_level = 8'h40;
      2'd1:    w_level = 8'h80;
      2'd2:    w_level = 8'hC0;
      default: w_level = 8'hFF;
    endcase

    w_star = r_vid_d1 & ({1'b0, r_lfsr[15:8]} < DENSITY);
  end

  // Frame edge detection and scroll offset. frame_tick is updated every
  // clock so it is exactly one pixel_clk wide even with a sparse pix_ce.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vsync_prev <= 1'b0;
      r_scroll_off <= 10'd0;
      frame_tick   <= 1'b0;
    end else begin
      frame_tick <= w_vs_rise;
      if (pix_ce) begin
        r_vsync_prev <= vsync_in;
        if (w_vs_rise && scroll_en) begin
          r_scroll_off <= w_scroll_next;
        end
      end
    end
  end

  // Three-stage pixel pipeline. The LFSR is reseeded throughout blanking so
  // the first visible pixel of a line sees the seed stepped once.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr    <= SEED | 16'h0001;
      r_vid_d1  <= 1'b0;
      r_hs_d1   <= 1'b0;
      r_vs_d1   <= 1'b0;
      r_star    <= 1'b0;
      r_level   <= 8'h00;
      r_de_d2   <= 1'b0;
      r_hs_d2   <= 1'b0;
      r_vs_d2   <= 1'b0;
      rgb_r     <= 8'h00;
      rgb_g     <= 8'h00;
      rgb_b     <= 8'h00;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      de_out    <= 1'b0;
    end else if (pix_ce) begin
      // stage 1
      r_lfsr   <= video_on_in ? w_lfsr_step : w_line_seed;
      r_vid_d1 <= video_on_in;
      r_hs_d1  <= hsync_in;
      r_vs_d1  <= vsync_in;
      // stage 2
      r_star   <= w_star;
      r_level  <= w_level;
      r_de_d2  <= r_vid_d1;
      r_hs_d2  <= r_hs_d1;
      r_vs_d2  <= r_vs_d1;
      // stage 3: star already includes the data-enable, so blank is black
      rgb_r     <= r_star ? r_level : 8'h00;
      rgb_g     <= r_star ? r_level : 8'h00;
      rgb_b     <= r_star ? r_level : 8'h00;
      hsync_out <= r_hs_d2;
      vsync_out <= r_vs_d2;
      de_out    <= r_de_d2;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_starfield_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_starfield_gen
// Purpose  : Self-checking bench for starfield_gen. Three instances share the
//            stimulus (DENSITY 12, 256 and 0) and are compared every clock
//            against a behavioural model; literal expectations pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_starfield_gen;

  localparam logic [15:0] c_SEED   = 16'hACE1;
  localparam int          c_WRAP   = 480;
  localparam int          c_HBLANK = 8;
  localparam int          c_HVIS   = 16;
`ifdef STARFIELD_TWINKLE_EN
  localparam bit          c_TWINKLE = 1'b1;
`else
  localparam bit          c_TWINKLE = 1'b0;
`endif

  logic       pixel_clk   = 1'b0;
  logic       reset_n     = 1'b0;
  logic       pix_ce      = 1'b0;
  logic [9:0] pixel_x     = '0;
  logic [9:0] pixel_y     = '0;
  logic       hsync_in    = 1'b0;
  logic       vsync_in    = 1'b0;
  logic       video_on_in = 1'b0;
  logic       scroll_en   = 1'b0;
  logic [2:0] speed       = '0;
  bit         ce_toggle   = 1'b0;

  logic [7:0] dflt_r, dflt_g, dflt_b, full_r, full_g, full_b, none_r, none_g, none_b;
  logic dflt_hs, dflt_vs, dflt_de, dflt_tick;
  logic full_hs, full_vs, full_de, full_tick;
  logic none_hs, none_vs, none_de, none_tick;

  always #5 pixel_clk = ~pixel_clk;

  starfield_gen u_dut (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .pix_ce(pix_ce), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .hsync_in(hsync_in), .vsync_in(vsync_in), .video_on_in(video_on_in),
    .scroll_en(scroll_en), .speed(speed), .rgb_r(dflt_r), .rgb_g(dflt_g), .rgb_b(dflt_b),
    .hsync_out(dflt_hs), .vsync_out(dflt_vs), .de_out(dflt_de), .frame_tick(dflt_tick));

  starfield_gen #(.DENSITY(9'd256)) u_full (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .pix_ce(pix_ce), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .hsync_in(hsync_in), .vsync_in(vsync_in), .video_on_in(video_on_in),
    .scroll_en(scroll_en), .speed(speed), .rgb_r(full_r), .rgb_g(full_g), .rgb_b(full_b),
    .hsync_out(full_hs), .vsync_out(full_vs), .de_out(full_de), .frame_tick(full_tick));

  starfield_gen #(.DENSITY(9'd0)) u_none (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .pix_ce(pix_ce), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .hsync_in(hsync_in), .vsync_in(vsync_in), .video_on_in(video_on_in),
    .scroll_en(scroll_en), .speed(speed), .rgb_r(none_r), .rgb_g(none_g), .rgb_b(none_b),
    .hsync_out(none_hs), .vsync_out(none_vs), .de_out(none_de), .frame_tick(none_tick));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int f_mod(input int a);
    return (a >= c_WRAP) ? a - c_WRAP : a;
  endfunction

  function automatic logic [15:0] f_seed(input int ys);
    return (16'(((ys % 1024) * 64) + 43) ^ c_SEED) | 16'h0001;
  endfunction

  function automatic logic [15:0] f_step(input logic [15:0] s);
    return (s >> 1) ^ ((s % 2 == 1) ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [7:0] f_level(input logic [15:0] s, input int fcnt);
    int idx;
    idx = int'(s[7:6]);
    if (c_TWINKLE && (fcnt % 16) >= 8 && s[5]) idx = idx ^ 2;
    case (idx)
      0:       return 8'h40;
      1:       return 8'h80;
      2:       return 8'hC0;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] f_pix(input logic [15:0] s, input logic vis,
                                       input int dens, input int fcnt);
    return (vis && int'(s[15:8]) < dens) ? f_level(s, fcnt) : 8'h00;
  endfunction

  // Expected 16-pixel line (DENSITY 256) for a line seeded from y_s.
  function automatic logic [127:0] f_line_sig(input int ys, input int fcnt);
    logic [15:0]  s;
    logic [127:0] sig;
    s   = f_seed(ys);
    sig = '0;
    for (int i = 0; i < c_HVIS; i++) begin
      s   = f_step(s);
      sig = {sig[119:0], f_level(s, fcnt)};
    end
    return sig;
  endfunction

  typedef struct packed {
    logic [7:0] lv_dflt;
    logic [7:0] lv_full;
    logic [7:0] lv_none;
    logic       hs;
    logic       vs;
    logic       de;
  } pix_t;

  pix_t        m_pipe [3];
  pix_t        e;
  logic [15:0] m_lfsr;
  int          m_scroll;
  logic        m_vprev;
  int          m_fcnt;
  logic        m_tick;
  logic        ce_s;
  int          n_ticks = 0;
  logic [127:0] q_sig[$];
  logic [7:0]   q_first[$];
  logic [127:0] cap_sig = '0;
  int           cap_len = 0;

  always @(posedge pixel_clk) begin
    logic rise;
    int   ys;
    pix_t p;
    ce_s = 1'b0;
    if (!reset_n) begin
      m_lfsr   = c_SEED | 16'h0001;
      m_scroll = 0;
      m_vprev  = 1'b0;
      m_fcnt   = 0;
      m_tick   = 1'b0;
      for (int i = 0; i < 3; i++) m_pipe[i] = '0;
    end else begin
      m_tick = 1'b0;
      if (pix_ce) begin
        ce_s    = 1'b1;
        ys      = f_mod(int'(pixel_y) + m_scroll);
        rise    = vsync_in & ~m_vprev;
        m_vprev = vsync_in;
        m_lfsr  = video_on_in ? f_step(m_lfsr) : f_seed(ys);
        if (rise) begin
          m_tick = 1'b1;
          m_fcnt = (m_fcnt + 1) % 16;
          if (scroll_en) m_scroll = f_mod(m_scroll + int'(speed));
        end
        p.lv_dflt = f_pix(m_lfsr, video_on_in, 12, m_fcnt);
        p.lv_full = f_pix(m_lfsr, video_on_in, 256, m_fcnt);
        p.lv_none = f_pix(m_lfsr, video_on_in, 0, m_fcnt);
        p.hs = hsync_in;
        p.vs = vsync_in;
        p.de = video_on_in;
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = p;
      end
    end
    #1;
    e = m_pipe[2];
    chk("rgb_dflt", {dflt_r, dflt_g, dflt_b}, {3{e.lv_dflt}});
    chk("rgb_full", {full_r, full_g, full_b}, {3{e.lv_full}});
    chk("rgb_none", {none_r, none_g, none_b}, {3{e.lv_none}});
    chk("sync_dflt", {dflt_hs, dflt_vs, dflt_de, dflt_tick}, {e.hs, e.vs, e.de, m_tick});
    chk("sync_full", {full_hs, full_vs, full_de, full_tick}, {e.hs, e.vs, e.de, m_tick});
    chk("sync_none", {none_hs, none_vs, none_de, none_tick}, {e.hs, e.vs, e.de, m_tick});
    if (dflt_tick) n_ticks++;
    // line capture of the DENSITY=256 instance, one sample per strobe
    if (ce_s) begin
      if (full_de) begin
        if (cap_len == 0) q_first.push_back(full_r);
        cap_sig = {cap_sig[119:0], full_r};
        cap_len++;
      end else if (cap_len > 0) begin
        q_sig.push_back(cap_sig);
        cap_sig = '0;
        cap_len = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int y, input int x, input logic vis, input logic hs, input logic vs);
    @(negedge pixel_clk);
    pixel_y     = 10'(y);
    pixel_x     = 10'(x);
    video_on_in = vis;
    hsync_in    = hs;
    vsync_in    = vs;
    pix_ce      = 1'b1;
    if (ce_toggle) begin
      @(negedge pixel_clk);
      pix_ce = 1'b0;
    end
  endtask

  task automatic line(input int y, input logic vis, input logic vs);
    for (int i = 0; i < c_HBLANK; i++) drive(y, c_HVIS + i, 1'b0, (i >= 2 && i < 5), vs);
    for (int i = 0; i < c_HVIS; i++) drive(y, i, vis, 1'b0, vs);
  endtask

  task automatic frame(input int rows);
    for (int r = 0; r < rows; r++) line(r, 1'b1, 1'b0);
    line(490, 1'b0, 1'b1);
    line(491, 1'b0, 1'b1);
  endtask

  task automatic vs_pulse();
    drive(500, 0, 1'b0, 1'b0, 1'b1);
    drive(500, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int t0;
    // reset state
    repeat (3) @(posedge pixel_clk);
    #1;
    chk("reset_rgb", {full_r, full_g, full_b, dflt_r, dflt_g, dflt_b}, '0);
    chk("reset_sync", {full_hs, full_vs, full_de, full_tick}, '0);
    @(negedge pixel_clk);
    reset_n = 1'b1;

    // scrolling by 3 lines per frame over 4 frames
    scroll_en = 1'b1;
    speed     = 3'd3;
    q_sig.delete();
    q_first.delete();
    n_ticks = 0;
    for (int f = 0; f < 4; f++) begin
      frame(8);
      chk("scroll_off_frame", 128'(u_dut.r_scroll_off), 128'(3 * (f + 1)));
    end
    chk("tick_count4", n_ticks, 4);
    chk("line_count", q_sig.size(), 32);
    chk("f0_first_pix", q_first[0], 8'h80);
    chk("f0_line6", q_sig[6], f_line_sig(6, 0));
    chk("f2_line0", q_sig[16], f_line_sig(6, 2));

    // wrap of scroll offset: 68*7 + 2 = 478, then +5 -> 3
    @(negedge pixel_clk); reset_n = 1'b0;
    @(negedge pixel_clk); reset_n = 1'b1;
    speed = 3'd7;
    repeat (68) vs_pulse();
    speed = 3'd2;
    vs_pulse();
    chk("scroll_478", 128'(u_dut.r_scroll_off), 128'd478);
    speed = 3'd5;
    vs_pulse();
    chk("scroll_wrap3", 128'(u_dut.r_scroll_off), 128'd3);
    q_sig.delete();
    q_first.delete();
    line(479, 1'b1, 1'b0);
    line(479, 1'b0, 1'b0);
    chk("y479_first_pix", q_first[0], 8'h40);
    chk("y479_line", q_sig[0], f_line_sig(2, 0));

    // pix_ce toggling every clock
    ce_toggle = 1'b1;
    speed     = 3'd1;
    q_sig.delete();
    q_first.delete();
    t0 = n_ticks;
    frame(4);
    chk("toggle_ticks", n_ticks, t0 + 1);
    chk("toggle_line0", q_sig[0], f_line_sig(3, 0));
    chk("toggle_scroll", 128'(u_dut.r_scroll_off), 128'd4);
    ce_toggle = 1'b0;

    // asynchronous reset in the middle of a visible line
    for (int i = 0; i < c_HBLANK; i++) drive(1, c_HVIS + i, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive(1, i, 1'b1, 1'b0, 1'b0);
    @(posedge pixel_clk);
    #2;
    chk("pre_reset_de", full_de, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_rgb", {full_r, full_g, full_b, dflt_r, dflt_g, dflt_b}, '0);
    chk("async_rst_sync", {full_hs, full_vs, full_de, dflt_hs, dflt_vs, dflt_de}, '0);
    @(posedge pixel_clk);
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    reset_n = 1'b1;
    for (int i = 8; i < c_HVIS; i++) drive(1, i, 1'b1, 1'b0, 1'b0);
    frame(8);
    frame(8);
    chk("post_reset_scroll", 128'(u_dut.r_scroll_off), 128'd2);

    repeat (4) @(posedge pixel_clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog actual=timeout required=finish @%0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
